// File: rtl/nes_bus_pkg.sv
// Shared definitions for the 2A03 system bus: DMA FSM states, register addresses
// and bus direction encodings.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_e;

  localparam logic [15:0] DefaultTriggerAddr = 16'h4014;
  localparam logic [15:0] DefaultOamDataAddr = 16'h2004;

  localparam logic RwRead  = 1'b1;
  localparam logic RwWrite = 1'b0;

endpackage

// File: rtl/bus_mux_2to1.sv
// CPU/DMA system bus selector; b_* wins whenever sel_i is high.
module bus_mux_2to1 (
  input  logic        sel_i,
  input  logic [15:0] a_addr_i,
  input  logic        a_rw_i,
  input  logic [7:0]  a_dout_i,
  input  logic [15:0] b_addr_i,
  input  logic        b_rw_i,
  input  logic [7:0]  b_dout_i,
  output logic [15:0] bus_addr_o,
  output logic        bus_rw_o,
  output logic [7:0]  bus_dout_o
);

  assign bus_addr_o = sel_i ? b_addr_i : a_addr_i;
  assign bus_rw_o   = sel_i ? b_rw_i   : a_rw_i;
  assign bus_dout_o = sel_i ? b_dout_i : a_dout_i;

endmodule

// File: rtl/oam_dma_controller.sv
// Sprite DMA: halts the CPU after a trigger write and copies one page to the OAM
// data port with alternating get/put cycles.
module oam_dma_controller
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] TriggerAddr = DefaultTriggerAddr,
  parameter logic [15:0] OamDataAddr = DefaultOamDataAddr,
  parameter int unsigned BurstLen    = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  cpu_dout_i,
  output logic        cpu_rdy_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_rw_o,
  output logic [7:0]  bus_dout_o,
  input  logic [7:0]  bus_din_i,
  output logic        dma_active_o
);

  localparam logic [7:0] LastIdx = 8'(BurstLen - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  byte_buf_q, byte_buf_d;
  logic        phase_q;
  logic        cpu_rdy_q, cpu_rdy_d;
  logic        dma_active_q, dma_active_d;

  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_dout;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    byte_buf_d = byte_buf_q;
    dma_addr   = cpu_addr_i;
    dma_rw     = RwRead;
    dma_dout   = byte_buf_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_rw_i == RwWrite && cpu_addr_i == TriggerAddr) begin
          page_d  = cpu_dout_i;
          idx_d   = '0;
          state_d = StHalt;
        end
      end
      StHalt: begin
        // The first CPU read after the trigger is the halt cycle; reads must land on get cycles.
        if (cpu_rw_i == RwRead) begin
          state_d = phase_q ? StRead : StAlign;
        end
      end
      StAlign: begin
        state_d = StRead;
      end
      StRead: begin
        dma_addr   = {page_q, idx_q};
        byte_buf_d = bus_din_i;
        state_d    = StWrite;
      end
      StWrite: begin
        dma_addr = OamDataAddr;
        dma_rw   = RwWrite;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase

    cpu_rdy_d    = (state_d == StIdle);
    dma_active_d = (state_d == StAlign) || (state_d == StRead) || (state_d == StWrite);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      page_q       <= '0;
      byte_buf_q   <= '0;
      phase_q      <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      byte_buf_q   <= byte_buf_d;
      phase_q      <= ~phase_q;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
    end
  end

  assign cpu_rdy_o    = cpu_rdy_q;
  assign dma_active_o = dma_active_q;

  bus_mux_2to1 u_bus_mux (
    .sel_i      (dma_active_q),
    .a_addr_i   (cpu_addr_i),
    .a_rw_i     (cpu_rw_i),
    .a_dout_i   (cpu_dout_i),
    .b_addr_i   (dma_addr),
    .b_rw_i     (dma_rw),
    .b_dout_i   (dma_dout),
    .bus_addr_o (bus_addr_o),
    .bus_rw_o   (bus_rw_o),
    .bus_dout_o (bus_dout_o)
  );

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Bus scheduler between the 2A03 CPU core and the shared system bus (memory, PPU registers).
- Detects a CPU write to the DMA trigger register, halts the CPU through RDY, then owns the bus to copy one 256-byte page to the PPU OAM data port.
- Returns the bus to the CPU when the copy completes.
- Sits between the `cpu_2a03` bus pins and the memory/PPU decode.

Parameters:
- TRIGGER_ADDR, 16'h4014: CPU write address that starts a transfer.
- OAM_DATA_ADDR, 16'h2004: destination address for every DMA write.
- BURST_LEN, 256: bytes per transfer. Must be a power of two, ≤256.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- cpu_rw  in  1  CPU read/write; 1 = read, 0 = write.
- cpu_dout  in  8  CPU write data.
- cpu_rdy  out  1  registered; 0 halts the CPU on its next read cycle.
- bus_addr  out  16  address driven to memory/PPU.
- bus_rw  out  1  read/write driven to memory/PPU.
- bus_dout  out  8  write data driven to memory/PPU.
- bus_din  in  8  read data returned from memory; valid at the next posedge after a read cycle.
- dma_active  out  1  high while the controller owns the bus.

Behaviour:
Reset:
- state=IDLE, cpu_rdy=1, dma_active=0, idx=0, page=0, byte_buf=0, phase=0.
- Reset asserted mid-transfer aborts immediately. The next cycle is IDLE with cpu_rdy=1; no further DMA writes occur.

Phase bit:
- Toggles every clock from reset. 0 = get cycle, 1 = put cycle.

Bus mux (combinational):
- dma_active=0: bus_* = cpu_*.
- dma_active=1: bus_* driven by the FSM.

FSM states:
- IDLE:
  - cpu_rdy=1.
  - If cpu_rw==0 and cpu_addr==TRIGGER_ADDR: latch page<=cpu_dout, idx<=0, go HALT.
  - The trigger write itself passes to the bus unchanged.
- HALT:
  - cpu_rdy=0 from the first cycle of this state.
  - While cpu_rw==0, the CPU is still finishing writes (RDY is ignored on writes). Bus stays with the CPU; remain in HALT.
  - When cpu_rw==1, this is the halt cycle: the CPU read is passed through and discarded by the CPU.
  - Then: if phase==1, go READ; else go ALIGN.
- ALIGN:
  - One dummy cycle. dma_active=1, bus_rw=1, bus_addr=cpu_addr (harmless re-read).
  - Go READ.
- READ:
  - Must always occur on phase==0.
  - dma_active=1, bus_rw=1, bus_addr={page, idx[7:0]}.
  - byte_buf<=bus_din at the following posedge, i.e. on entry to WRITE, using the memory's half-cycle-late data.
  - Go WRITE.
- WRITE:
  - dma_active=1, bus_rw=0, bus_addr=OAM_DATA_ADDR, bus_dout=byte_buf.
  - If idx==BURST_LEN-1: go IDLE, cpu_rdy<=1, dma_active<=0.
  - Else: idx<=idx+1, go READ.

Widths and timing:
- idx is 8 bits; no carry into page. A transfer never crosses a page boundary.
- Total CPU stall, counted from the halt cycle to the first resumed CPU cycle: 513 cycles if the halt cycle is a put cycle, 514 otherwise.

Boundary cases:
- A trigger write while dma_active cannot originate from the CPU (it is halted); any such match is ignored.
- Back-to-back triggers: a second trigger is accepted in the first IDLE cycle after completion.
- cpu_rdy is 1 in the same cycle the bus returns to the CPU.

Decomposition:
- Shared package `nes_bus_pkg`:
  - FSM state encoding localparams (IDLE, HALT, ALIGN, READ, WRITE).
  - Register address constants (4014, 2004).
  - RW_READ / RW_WRITE constants.
- One natural sub-module: `bus_mux_2to1`, the combinational CPU/DMA bus selector, kept separate so a future DMC DMA requester can extend it into an arbiter.
- The FSM and counters stay in the top module.

Test Plan:
- Memory page $02 holds bytes = index; CPU writes $02 to $4014 during a put halt cycle. Expect exactly 256 writes to $2004 with data $00..$FF in order, and cpu_rdy low for 513 cycles.
- Same stimulus but the halt cycle lands on a get cycle. Expect one ALIGN cycle, and cpu_rdy low for 514 cycles.
- Trigger followed by two more CPU write cycles (e.g. a stack push). Expect the controller to stay in HALT with bus passthrough until the first cpu_rw=1, then start the transfer with no lost CPU writes.
- Assert reset at idx=$80, in WRITE. Expect the next cycle IDLE, cpu_rdy=1, dma_active=0, and no further $2004 writes; a new $4014 write restarts at idx=0.
- Page $FF source ($FF00-$FFFF). Expect idx to wrap correctly, the last read to be $FFFF, and no access at $0000.
- Idle CPU traffic (reads/writes to $0000-$07FF, $4015): expect bus_* == cpu_* every cycle and cpu_rdy to stay 1.
